ex_operand_stage: RTL and testbench
===================================

// Module: ex_operand_stage
// PURPOSE
//  ID->EX pipeline register feeding the EX-stage 3:1 operand-forwarding muxes.
//  - Latches decoded operands and control.
//  - Precomputes registered 2-bit forward selects for operands A/B.
//  - Detects load-use hazards: stalls ID and injects a bubble.
//  Sits between decode/regfile read and the EX forwarding muxes + ALU.
// PARAMETERS
//  DATA_W   34  operand/result data width (matches EX datapath muxes)
//  RADDR_W  4   register address width; address 0 is hardwired zero
//  CNT_W    16  width of saturating bubble counter
// PORTS
//  clk              in   1        single clock, rising edge
//  rst              in   1        synchronous, active-high reset
//  id_valid         in   1        ID holds a valid instruction
//  id_rs1           in   RADDR_W  source reg A address
//  id_rs2           in   RADDR_W  source reg B address
//  id_rd            in   RADDR_W  destination address
//  id_rs1_data      in   DATA_W   regfile read A
//  id_rs2_data      in   DATA_W   regfile read B
//  id_reg_write     in   1        instr writes rd
//  id_mem_read      in   1        instr is a load
//  mem_rd           in   RADDR_W  rd of instr currently in MEM
//  mem_reg_write    in   1        MEM instr writes rd (already qualified by MEM valid)
//  flush_i          in   1        branch/exception flush of ID->EX
//  hold_i           in   1        downstream stall: freeze EX register
//  stall_o          out  1        freeze PC and IF/ID this cycle
//  ex_valid         out  1        EX holds a valid instruction
//  ex_rs1_data      out  DATA_W   latched operand A (mux input a)
//  ex_rs2_data      out  DATA_W   latched operand B (mux input a)
//  ex_rd            out  RADDR_W  latched destination
//  ex_reg_write     out  1        latched, forced 0 when ex_valid=0
//  ex_mem_read      out  1        latched, forced 0 when ex_valid=0
//  ex_fwd_a_sel     out  2        select for operand-A forwarding mux
//  ex_fwd_b_sel     out  2        select for operand-B forwarding mux
//  bubble_cnt       out  CNT_W    saturating count of injected load-use bubbles
// BEHAVIOUR
//  Reset: every output and internal register is 0. stall_o=0 while rst=1.
//  Latency: 1 cycle, ID inputs to ex_* outputs.
//  load_use (combinational):
//    ex_valid & ex_mem_read & id_valid & ex_rd!=0
//    & (ex_rd==id_rs1 | ex_rd==id_rs2)
//  stall_o = load_use | hold_i.
//  Update priority each rising edge:
//    1. rst   : all outputs cleared
//    2. flush : ex_valid<=0, ex_reg_write<=0, ex_mem_read<=0, sels<=00;
//               wins over hold_i and load_use
//    3. hold_i: all ex_* outputs and bubble_cnt keep their values
//    4. load_use: bubble. ex_valid<=0, ex_reg_write<=0, ex_mem_read<=0,
//               sels<=00, bubble_cnt+=1 (saturate at all-ones)
//    5. normal: latch all id_* fields; ex_valid<=id_valid;
//               control bits gated by id_valid
//  Forward select, per operand; rs = id_rs1 or id_rs2, evaluated at the latch edge:
//    - 2'b10 (MEM-stage result): ex_valid & ex_reg_write & ex_rd==rs & rs!=0
//      (instr now in EX reaches MEM next cycle)
//    - 2'b01 (WB-stage result): else mem_reg_write & mem_rd==rs & rs!=0
//    - 2'b00 (regfile value): otherwise
//    - 2'b11: never driven (the mux returns zero for it)
//    - Both matches true: younger (EX) wins, giving 2'b10.
//    - Same-cycle WB write vs. ID read: resolved by regfile write-through,
//      not by this block.
//  Back-to-back load-use: one bubble only.
//    The bubble clears ex_mem_read, so the next cycle proceeds.
//  Reset mid-stall: next cycle ex_valid=0, stall_o=0, bubble_cnt=0.
// STRUCTURE
//  Shared package (cpu_pkg):
//    - fwd_sel_t enum FWD_REG=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10
//    - DATA_W and RADDR_W defaults
//  Sub-module fwd_sel_calc: combinational priority comparator, rs -> fwd_sel_t.
//    Instantiated twice, for A and B.
//  Top: hazard detect, priority update register, bubble counter.
// TESTING
//  T1 Reset: rst=1 for 2 cycles with random inputs
//     -> all outputs 0, stall_o=0.
//  T2 EX forward: add r3 (ex_reg_write, ex_rd=3), then ID rs1=3
//     -> ex_fwd_a_sel=2'b10, ex_fwd_b_sel=2'b00.
//  T3 WB forward + x0: mem_rd=5, mem_reg_write=1, ID rs2=5
//     -> b_sel=01; repeat with mem_rd=0, rs2=0 -> b_sel=00.
//  T4 Load-use: EX load ex_rd=7, ID rs1=7
//     -> stall_o=1 for 1 cycle, next ex_valid=0, bubble_cnt=1;
//     following cycle ID latched with a_sel=01.
//  T5 Flush vs hold: flush_i=1 and hold_i=1 together
//     -> ex_valid=0 next cycle.
//     hold_i alone for 3 cycles -> ex_* and bubble_cnt unchanged, stall_o=1.
//  T6 Saturation: force 2^CNT_W+2 load-use events
//     -> bubble_cnt stays at all-ones.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the EX-stage operand path: forwarding-select
// encoding and default datapath widths.
package cpu_pkg;

  localparam int DEFAULT_DATA_W  = 34;
  localparam int DEFAULT_RADDR_W = 4;

  // Encoding of the EX forwarding mux select; 2'b11 is never produced
  // (the mux returns zero for it).
  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

endpackage

// File: rtl/fwd_sel_calc.sv
// Priority comparator turning one source register address into a
// forwarding select. The instruction currently in EX is younger than the
// one in MEM, so its match wins. Register 0 never forwards.
module fwd_sel_calc
  import cpu_pkg::*;
#(
  parameter int RADDR_W = DEFAULT_RADDR_W
) (
  input  logic [RADDR_W-1:0] rs,
  input  logic               ex_valid,
  input  logic               ex_reg_write,
  input  logic [RADDR_W-1:0] ex_rd,
  input  logic               mem_reg_write,
  input  logic [RADDR_W-1:0] mem_rd,
  output logic [1:0]         sel
);

  // EX match beats MEM match; zero register always reads the regfile
  always_comb begin
    sel = FWD_REG;
    if (rs != '0) begin
      if (ex_valid && ex_reg_write && (ex_rd == rs)) begin
        sel = FWD_MEM;
      end else if (mem_reg_write && (mem_rd == rs)) begin
        sel = FWD_WB;
      end
    end
  end

endmodule

// File: rtl/ex_operand_stage.sv
// ID->EX pipeline register. Latches decoded operands/control, registers
// the operand forwarding selects, and detects load-use hazards (stall ID,
// inject one bubble, count bubbles with saturation).
module ex_operand_stage
  import cpu_pkg::*;
#(
  parameter int DATA_W  = DEFAULT_DATA_W,
  parameter int RADDR_W = DEFAULT_RADDR_W,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               id_valid,
  input  logic [RADDR_W-1:0] id_rs1,
  input  logic [RADDR_W-1:0] id_rs2,
  input  logic [RADDR_W-1:0] id_rd,
  input  logic [DATA_W-1:0]  id_rs1_data,
  input  logic [DATA_W-1:0]  id_rs2_data,
  input  logic               id_reg_write,
  input  logic               id_mem_read,
  input  logic [RADDR_W-1:0] mem_rd,
  input  logic               mem_reg_write,
  input  logic               flush_i,
  input  logic               hold_i,
  output logic               stall_o,
  output logic               ex_valid,
  output logic [DATA_W-1:0]  ex_rs1_data,
  output logic [DATA_W-1:0]  ex_rs2_data,
  output logic [RADDR_W-1:0] ex_rd,
  output logic               ex_reg_write,
  output logic               ex_mem_read,
  output logic [1:0]         ex_fwd_a_sel,
  output logic [1:0]         ex_fwd_b_sel,
  output logic [CNT_W-1:0]   bubble_cnt
);

  logic       load_use;
  logic [1:0] fwd_a;
  logic [1:0] fwd_b;

  // A load in EX whose nonzero destination is read by the instruction in ID
  always_comb begin
    load_use = ex_valid && ex_mem_read && id_valid && (ex_rd != '0)
               && ((ex_rd == id_rs1) || (ex_rd == id_rs2));
  end

  // Stall is suppressed during reset so a mid-stall reset releases ID at once
  assign stall_o = !rst && (load_use || hold_i);

  fwd_sel_calc #(.RADDR_W(RADDR_W)) u_fwd_a (
    .rs            (id_rs1),
    .ex_valid      (ex_valid),
    .ex_reg_write  (ex_reg_write),
    .ex_rd         (ex_rd),
    .mem_reg_write (mem_reg_write),
    .mem_rd        (mem_rd),
    .sel           (fwd_a)
  );

  fwd_sel_calc #(.RADDR_W(RADDR_W)) u_fwd_b (
    .rs            (id_rs2),
    .ex_valid      (ex_valid),
    .ex_reg_write  (ex_reg_write),
    .ex_rd         (ex_rd),
    .mem_reg_write (mem_reg_write),
    .mem_rd        (mem_rd),
    .sel           (fwd_b)
  );

  // Priority update: reset > flush > hold > load-use bubble > normal latch.
  // Selects are gated with id_valid so an invalid EX slot always shows 00.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid     <= 1'b0;
      ex_rs1_data  <= '0;
      ex_rs2_data  <= '0;
      ex_rd        <= '0;
      ex_reg_write <= 1'b0;
      ex_mem_read  <= 1'b0;
      ex_fwd_a_sel <= FWD_REG;
      ex_fwd_b_sel <= FWD_REG;
      bubble_cnt   <= '0;
    end else if (flush_i) begin
      ex_valid     <= 1'b0;
      ex_reg_write <= 1'b0;
      ex_mem_read  <= 1'b0;
      ex_fwd_a_sel <= FWD_REG;
      ex_fwd_b_sel <= FWD_REG;
    end else if (!hold_i) begin
      if (load_use) begin
        ex_valid     <= 1'b0;
        ex_reg_write <= 1'b0;
        ex_mem_read  <= 1'b0;
        ex_fwd_a_sel <= FWD_REG;
        ex_fwd_b_sel <= FWD_REG;
        if (bubble_cnt != '1) begin
          bubble_cnt <= bubble_cnt + CNT_W'(1);
        end
      end else begin
        ex_valid     <= id_valid;
        ex_rs1_data  <= id_rs1_data;
        ex_rs2_data  <= id_rs2_data;
        ex_rd        <= id_rd;
        ex_reg_write <= id_valid && id_reg_write;
        ex_mem_read  <= id_valid && id_mem_read;
        ex_fwd_a_sel <= id_valid ? fwd_a : FWD_REG;
        ex_fwd_b_sel <= id_valid ? fwd_b : FWD_REG;
      end
    end
  end

endmodule

// File: tb/tb_ex_operand_stage.sv
// Scoreboard bench for ex_operand_stage. The driver applies inputs at the
// falling edge and pushes the expected visible state (plus expected stall)
// computed by a behavioural pipeline model; the monitor pops and compares
// a few ns later. A narrow bubble counter keeps saturation reachable.
module tb_ex_operand_stage;

  localparam int DW = 34;
  localparam int AW = 4;
  localparam int CW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          id_valid;
  logic [AW-1:0] id_rs1, id_rs2, id_rd;
  logic [DW-1:0] id_rs1_data, id_rs2_data;
  logic          id_reg_write, id_mem_read;
  logic [AW-1:0] mem_rd;
  logic          mem_reg_write;
  logic          flush_i, hold_i;
  logic          stall_o, ex_valid;
  logic [DW-1:0] ex_rs1_data, ex_rs2_data;
  logic [AW-1:0] ex_rd;
  logic          ex_reg_write, ex_mem_read;
  logic [1:0]    ex_fwd_a_sel, ex_fwd_b_sel;
  logic [CW-1:0] bubble_cnt;

  always #5 clk = ~clk;

  ex_operand_stage #(.DATA_W(DW), .RADDR_W(AW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rd(id_rd), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .mem_rd(mem_rd),
    .mem_reg_write(mem_reg_write), .flush_i(flush_i), .hold_i(hold_i),
    .stall_o(stall_o), .ex_valid(ex_valid), .ex_rs1_data(ex_rs1_data),
    .ex_rs2_data(ex_rs2_data), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_fwd_a_sel(ex_fwd_a_sel),
    .ex_fwd_b_sel(ex_fwd_b_sel), .bubble_cnt(bubble_cnt)
  );

  // Model of the instruction slot in EX
  typedef struct {
    logic          v;
    logic [DW-1:0] d1, d2;
    logic [AW-1:0] rd;
    logic          rw, mr;
    logic [1:0]    fa, fb;
    int            bubbles;
  } slot_t;

  typedef struct {
    slot_t s;
    logic  stall;
    logic  known;
  } exp_t;

  exp_t  sb[$];
  slot_t model;
  logic  model_known = 1'b0;
  int    n_chk = 0;
  int    n_fail = 0;
  logic [63:0] r64;

  // Where operand rs comes from in EX next cycle: the instruction now in EX
  // is about to be in MEM, the one now in MEM is about to be in WB.
  function automatic logic [1:0] source_of(input logic [AW-1:0] rs, input slot_t m);
    if (rs == 0) return 2'd0;
    if (m.v && m.rw && m.rd == rs) return 2'd2;
    if (mem_reg_write && mem_rd == rs) return 2'd1;
    return 2'd0;
  endfunction

  function automatic logic hazard(input slot_t m);
    return m.v && m.mr && id_valid && m.rd != 0 && (m.rd == id_rs1 || m.rd == id_rs2);
  endfunction

  function automatic slot_t advance(input slot_t m);
    slot_t n = m;
    if (rst) begin
      n.v = 0; n.d1 = '0; n.d2 = '0; n.rd = '0; n.rw = 0; n.mr = 0;
      n.fa = 0; n.fb = 0; n.bubbles = 0;
    end else if (flush_i) begin
      n.v = 0; n.rw = 0; n.mr = 0; n.fa = 0; n.fb = 0;
    end else if (hold_i) begin
      n = m;
    end else if (hazard(m)) begin
      n.v = 0; n.rw = 0; n.mr = 0; n.fa = 0; n.fb = 0;
      n.bubbles = m.bubbles + 1;
    end else begin
      n.v  = id_valid;
      n.d1 = id_rs1_data;
      n.d2 = id_rs2_data;
      n.rd = id_rd;
      n.rw = id_valid && id_reg_write;
      n.mr = id_valid && id_mem_read;
      n.fa = id_valid ? source_of(id_rs1, m) : 2'd0;
      n.fb = id_valid ? source_of(id_rs2, m) : 2'd0;
    end
    return n;
  endfunction

  function automatic logic [CW-1:0] sat_cnt(input int b);
    if (b >= (1 << CW) - 1) return {CW{1'b1}};
    return CW'(b);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Push the expectation for this cycle, then advance the model over the edge
  task automatic tick();
    exp_t e;
    e.s     = model;
    e.known = model_known;
    e.stall = rst ? 1'b0 : (hold_i || (model_known && hazard(model)));
    sb.push_back(e);
    model = advance(model);
    if (rst) model_known = 1'b1;
    @(negedge clk);
  endtask

  task automatic idle();
    rst = 0; flush_i = 0; hold_i = 0; id_valid = 0;
    id_rs1 = 0; id_rs2 = 0; id_rd = 0; id_reg_write = 0; id_mem_read = 0;
    mem_rd = 0; mem_reg_write = 0;
  endtask

  task automatic rnd_data();
    r64 = {$urandom, $urandom}; id_rs1_data = r64[DW-1:0];
    r64 = {$urandom, $urandom}; id_rs2_data = r64[DW-1:0];
  endtask

  task automatic instr(input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                       input logic [AW-1:0] rd, input logic rw, input logic mr);
    id_valid = 1; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
    id_reg_write = rw; id_mem_read = mr; rnd_data();
  endtask

  // Monitor: compare the DUT against each queued expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("stall_o", 64'(stall_o), 64'(e.stall));
        if (e.known) begin
          chk("ex_valid", 64'(ex_valid), 64'(e.s.v));
          chk("ex_reg_write", 64'(ex_reg_write), 64'(e.s.rw));
          chk("ex_mem_read", 64'(ex_mem_read), 64'(e.s.mr));
          chk("ex_fwd_a_sel", 64'(ex_fwd_a_sel), 64'(e.s.fa));
          chk("ex_fwd_b_sel", 64'(ex_fwd_b_sel), 64'(e.s.fb));
          chk("bubble_cnt", 64'(bubble_cnt), 64'(sat_cnt(e.s.bubbles)));
          if (e.s.v) begin
            chk("ex_rd", 64'(ex_rd), 64'(e.s.rd));
            chk("ex_rs1_data", 64'(ex_rs1_data), 64'(e.s.d1));
            chk("ex_rs2_data", 64'(ex_rs2_data), 64'(e.s.d2));
          end
        end
      end
    end
  end

  // Driver
  initial begin
    model = '{v: 0, d1: '0, d2: '0, rd: '0, rw: 0, mr: 0, fa: 0, fb: 0, bubbles: 0};
    idle();
    id_rs1_data = '0; id_rs2_data = '0;
    @(negedge clk);

    // T1: reset with random inputs
    for (int i = 0; i < 2; i++) begin
      instr(AW'($urandom), AW'($urandom), AW'($urandom), 1'($urandom), 1'($urandom));
      mem_rd = AW'($urandom); mem_reg_write = 1'($urandom);
      flush_i = 1'($urandom); hold_i = 1'($urandom); rst = 1;
      tick();
    end
    idle(); tick();

    // T2: EX forward
    instr(1, 2, 3, 1, 0); tick();
    instr(3, 4, 6, 1, 0); tick();

    // T3: WB forward, then x0 never forwards
    idle(); tick();
    instr(1, 5, 8, 1, 0); mem_rd = 5; mem_reg_write = 1; tick();
    instr(1, 0, 8, 1, 0); mem_rd = 0; mem_reg_write = 1; tick();
    idle(); tick();

    // T4: load-use, one bubble, then WB forward from the load in MEM
    instr(1, 2, 7, 1, 1); tick();
    instr(7, 2, 9, 1, 0); tick();
    mem_rd = 7; mem_reg_write = 1; tick();
    idle(); tick();

    // T5: flush beats hold; hold alone freezes everything
    instr(1, 2, 10, 1, 1); tick();
    instr(3, 4, 11, 1, 0); flush_i = 1; hold_i = 1; tick();
    idle(); instr(5, 6, 12, 1, 1); tick();
    for (int i = 0; i < 3; i++) begin
      instr(12, 12, 13, 1, 0); hold_i = 1; tick();
    end
    idle(); tick();

    // T6: saturate the bubble counter with back-to-back load-use
    instr(1, 1, 1, 1, 1);
    for (int i = 0; i < 2 * ((1 << CW) + 2) + 1; i++) tick();
    idle(); tick();

    // Reset mid-stall
    instr(1, 2, 4, 1, 1); tick();
    instr(4, 4, 5, 1, 0); tick();
    rst = 1; tick();
    rst = 0; tick();
    idle(); tick();

    // Random traffic on a small register set to provoke hazards
    for (int i = 0; i < 3000; i++) begin
      rst           = ($urandom_range(0, 59) == 0);
      flush_i       = ($urandom_range(0, 9) == 0);
      hold_i        = ($urandom_range(0, 7) == 0);
      id_valid      = ($urandom_range(0, 3) != 0);
      id_rs1        = AW'($urandom_range(0, 3));
      id_rs2        = AW'($urandom_range(0, 3));
      id_rd         = AW'($urandom_range(0, 3));
      id_reg_write  = 1'($urandom_range(0, 1));
      id_mem_read   = ($urandom_range(0, 2) == 0);
      mem_rd        = AW'($urandom_range(0, 3));
      mem_reg_write = 1'($urandom_range(0, 1));
      rnd_data();
      tick();
    end
    idle();

    for (int i = 0; i < 5 && sb.size() > 0; i++) @(negedge clk);
    #5;
    if (sb.size() != 0) begin
      n_chk++; n_fail++;
      $display("FAIL scoreboard_drain actual=%0d expected=0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
